instr_mem_loader: RTL and testbench

//   Boot-time program loader upstream of single_cycle_cpu. Receives a byte stream over
//   a valid/ready interface and packs it little-endian into 32-bit instruction words.

---
 rtl/instr_mem_loader.sv | 128 ++++++++++++
 tb/tb_instr_mem_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a little-endian byte stream into 32-bit words, writes them to
// instruction memory and holds the CPU in reset until the whole program is loaded.
module instr_mem_loader #(
    parameter int MEM_SIZE       = 64,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] MAX_WC = 16'(MEM_SIZE);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

    state_t      state_q;
    logic [1:0]  byte_idx_q;
    logic [31:0] word_q, word_d;
    logic [15:0] wc_q, words_loaded_q, words_loaded_d;
    logic [TW-1:0] tmo_q;
    logic        byte_ready_q, mem_we_q, cpu_rst_q, busy_q, done_q, error_q;
    logic [31:0] mem_addr_q, mem_wdata_q;

    // bytes shift in from the top so byte 0 ends up in [7:0] after four transfers
    assign word_d         = {byte_data, word_q[31:8]};
    assign words_loaded_d = words_loaded_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            byte_idx_q     <= 2'd0;
            word_q         <= 32'd0;
            wc_q           <= 16'd0;
            words_loaded_q <= 16'd0;
            tmo_q          <= '0;
            byte_ready_q   <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
            cpu_rst_q      <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                RECV: begin
                    if (byte_valid) begin
                        word_q     <= word_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        tmo_q      <= '0;
                        if (byte_idx_q == 2'd3) begin
                            state_q      <= WRITE;
                            byte_ready_q <= 1'b0;
                            mem_we_q     <= 1'b1;
                            mem_addr_q   <= {14'd0, words_loaded_q, 2'b00};
                            mem_wdata_q  <= word_d;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q      <= ERR;
                        byte_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                        error_q      <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                WRITE: begin
                    words_loaded_q <= words_loaded_d;
                    if (words_loaded_d == wc_q) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        cpu_rst_q <= 1'b0;
                    end else begin
                        state_q      <= RECV;
                        byte_ready_q <= 1'b1;
                        tmo_q        <= '0;
                    end
                end
                default: begin
                    if (start) begin
                        cpu_rst_q <= 1'b1;
                        done_q    <= 1'b0;
                        if (word_count == 16'd0 || word_count > MAX_WC) begin
                            state_q      <= ERR;
                            byte_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                            error_q      <= 1'b1;
                        end else begin
                            state_q        <= RECV;
                            wc_q           <= word_count;
                            words_loaded_q <= 16'd0;
                            byte_idx_q     <= 2'd0;
                            tmo_q          <= '0;
                            byte_ready_q   <= 1'b1;
                            busy_q         <= 1'b1;
                            error_q        <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign byte_ready   = byte_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: scoreboard bench for instr_mem_loader; expected writes are queued
// as words are sent and matched against every mem_we pulse.
module tb_instr_mem_loader;
    localparam int MEM_SIZE = 64;
    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        rst, start, byte_valid, byte_ready, mem_we, cpu_rst, busy, done, error;
    logic [15:0] word_count, words_loaded;
    logic [7:0]  byte_data;
    logic [31:0] mem_addr, mem_wdata;

    logic [63:0] sb[$];
    logic [31:0] img[$];
    int total = 0;
    int bad = 0;

    instr_mem_loader #(.MEM_SIZE(MEM_SIZE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) chk("spurious_we", {mem_addr, mem_wdata}, 64'hx);
            else chk("write", {mem_addr, mem_wdata}, sb.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] wc);
        start = 1'b1;
        word_count = wc;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        cyc(gap);
        byte_valid = 1'b1;
        byte_data = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            cyc(1);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 1, 0);
        cyc(1);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input int idx, input logic [31:0] w, input int maxgap);
        sb.push_back({32'(idx * 4), w});
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], maxgap > 0 ? int'($urandom_range(maxgap, 0)) : 0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            cyc(1);
            n++;
        end
        chk("done", done, 1);
        chk("cpu_rst_done", cpu_rst, 0);
        chk("busy_done", busy, 0);
        chk("err_done", error, 0);
    endtask

    task automatic load(input int wc, input int maxgap);
        pulse_start(16'(wc));
        chk("busy_start", busy, 1);
        chk("ready_start", byte_ready, 1);
        for (int i = 0; i < wc; i++) send_word(i, img[i], maxgap);
        wait_done();
        chk("words_loaded", words_loaded, 16'(wc));
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        word_count = 16'd0;
        byte_valid = 1'b0;
        byte_data = 8'd0;
        cyc(2);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_outs", {byte_ready, mem_we, busy, done, error}, 0);
        chk("rst_wl", words_loaded, 0);
        rst = 1'b0;
        cyc(1);
        chk("idle_cpu_rst", cpu_rst, 1);

        img = '{32'h00000013, 32'h00100093};
        load(2, 0);
        load(2, 7);

        pulse_start(16'd0);
        chk("wc0_err", error, 1);
        chk("wc0_cpu_rst", cpu_rst, 1);
        chk("wc0_done", done, 0);
        pulse_start(16'(MEM_SIZE + 1));
        chk("wcbig_err", error, 1);
        chk("wcbig_busy", busy, 0);
        chk("wcbig_cpu_rst", cpu_rst, 1);

        pulse_start(16'd1);
        chk("restart_err_clr", error, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        n = 0;
        while (!error && n < TMO + 20) begin
            cyc(1);
            n++;
        end
        chk("tmo_err", error, 1);
        chk("tmo_cycles_ok", n >= TMO && n <= TMO + 1, 1);
        chk("tmo_ready", byte_ready, 0);
        chk("tmo_cpu_rst", cpu_rst, 1);
        img = '{32'hDEADBEEF};
        load(1, 0);

        img = '{32'hA1B2C3D4, 32'h0badf00d, 32'h12345678};
        pulse_start(16'd3);
        send_word(0, img[0], 0);
        sb.push_back({32'd4, img[1]});
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_cpu_rst", cpu_rst, 1);
        chk("arst_outs", {byte_ready, mem_we, busy, done, error}, 0);
        chk("arst_wl", words_loaded, 0);
        chk("arst_addr", mem_addr, 0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1);
        load(3, 2);

        img = '{32'hCAFEF00D, 32'h00000073, 32'h11112222};
        pulse_start(16'd2);
        send_word(0, img[0], 0);
        pulse_start(16'd5);
        chk("busy_start_ignored", busy, 1);
        send_word(1, img[1], 0);
        wait_done();
        chk("ignored_wl", words_loaded, 2);
        pulse_start(16'd1);
        chk("done_restart_cpu_rst", cpu_rst, 1);
        chk("done_restart_wl", words_loaded, 0);
        chk("done_restart_done", done, 0);
        send_word(0, img[2], 3);
        wait_done();
        chk("reload_wl", words_loaded, 1);
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
